// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state encoding and clear-start helper for the parametrised register file
package regfile_pkg;
  typedef enum logic {IDLE, CLEAR} state_e;
  function automatic int first_entry(input int zero_reg);
    return (zero_reg != 0) ? 1 : 0;
  endfunction
endpackage

// File: rtl/regfile_param_if.sv
// regfile_param_if: decode-side write/read/clear bus of the register file
interface regfile_param_if #(parameter int WIDTH = 32, parameter int ADDR_W = 5);
  logic [WIDTH-1:0]  WriteData;
  logic [ADDR_W-1:0] WriteRegister;
  logic              RegWrite;
  logic [ADDR_W-1:0] ReadRegister1;
  logic [ADDR_W-1:0] ReadRegister2;
  logic [WIDTH-1:0]  ReadData1;
  logic [WIDTH-1:0]  ReadData2;
  logic              ClearReq;
  logic              Busy;
  logic              WriteErr;
  modport master (
    output WriteData, WriteRegister, RegWrite, ReadRegister1, ReadRegister2, ClearReq,
    input  ReadData1, ReadData2, Busy, WriteErr
  );
  modport slave (
    input  WriteData, WriteRegister, RegWrite, ReadRegister1, ReadRegister2, ClearReq,
    output ReadData1, ReadData2, Busy, WriteErr
  );
endinterface

// File: rtl/regfile_clear_fsm.sv
// regfile_clear_fsm: walks the array one entry per cycle to zero it and flags writes dropped while busy
module regfile_clear_fsm import regfile_pkg::*; #(
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_req,
  input  logic              reg_write,
  output logic              busy,
  output logic              write_err,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr
);
  localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(first_entry(ZERO_REG));
  localparam logic [ADDR_W-1:0] LAST  = '1;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              err_q, err_d;
  assign busy      = (state_q == CLEAR);
  assign clr_en    = busy;
  assign clr_addr  = cnt_q;
  assign write_err = err_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = reg_write && busy;
    if (state_q == IDLE && clear_req) begin
      state_d = CLEAR;
      cnt_d   = FIRST;
    end else if (state_q == CLEAR) begin
      cnt_d   = cnt_q + 1'b1;
      state_d = (cnt_q == LAST) ? IDLE : CLEAR;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: rtl/regfile_param.sv
// regfile_param: 2-read/1-write register file with optional zero register, write bypass and sequential clear
module regfile_param import regfile_pkg::*; #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 0
) (
  input logic           Clk,
  input logic           Reset_n,
  regfile_param_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic              busy, clr_en, we_ok;
  logic [ADDR_W-1:0] clr_addr;
  regfile_clear_fsm #(.ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_clr (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .clear_req (bus.ClearReq),
    .reg_write (bus.RegWrite),
    .busy      (busy),
    .write_err (bus.WriteErr),
    .clr_en    (clr_en),
    .clr_addr  (clr_addr)
  );
  assign bus.Busy = busy;
  // a protected entry 0 is never written, so it also never bypasses
  assign we_ok = bus.RegWrite && !busy && !(ZERO_REG != 0 && bus.WriteRegister == '0);
  assign bus.ReadData1 = (ZERO_REG != 0 && bus.ReadRegister1 == '0) ? '0 :
                         (BYPASS != 0 && we_ok && bus.ReadRegister1 == bus.WriteRegister) ? bus.WriteData :
                         mem_q[bus.ReadRegister1];
  assign bus.ReadData2 = (ZERO_REG != 0 && bus.ReadRegister2 == '0) ? '0 :
                         (BYPASS != 0 && we_ok && bus.ReadRegister2 == bus.WriteRegister) ? bus.WriteData :
                         mem_q[bus.ReadRegister2];
  always_comb begin
    mem_d = mem_q;
    if (we_ok) mem_d[bus.WriteRegister] = bus.WriteData;
    if (clr_en) mem_d[clr_addr] = '0;
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) mem_q <= '{default: '0};
    else mem_q <= mem_d;
  end
endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: directed checks on a zero-reg/no-bypass instance (a) and a plain-r0/bypass instance (b)
module tb_regfile_param;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] wd = '0;
  logic [4:0]  wa = '0, rr1 = '0, rr2 = '0;
  logic        we = 1'b0, clr = 1'b0;
  int          checks = 0, failures = 0, na = 0, nb = 0;
  always #5 clk = ~clk;
  regfile_param_if #(.WIDTH(32), .ADDR_W(5)) a();
  regfile_param_if #(.WIDTH(32), .ADDR_W(5)) b();
  assign a.WriteData = wd;
  assign a.WriteRegister = wa;
  assign a.RegWrite = we;
  assign a.ReadRegister1 = rr1;
  assign a.ReadRegister2 = rr2;
  assign a.ClearReq = clr;
  assign b.WriteData = wd;
  assign b.WriteRegister = wa;
  assign b.RegWrite = we;
  assign b.ReadRegister1 = rr1;
  assign b.ReadRegister2 = rr2;
  assign b.ClearReq = clr;
  regfile_param #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut_a (.Clk(clk), .Reset_n(rst_n), .bus(a.slave));
  regfile_param #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(1)) dut_b (.Clk(clk), .Reset_n(rst_n), .bus(b.slave));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    we = 1'b1;
    wa = addr;
    wd = data;
    @(negedge clk);
    we = 1'b0;
  endtask
  initial begin
    #3 rst_n = 1'b0;
    #1;
    chk("rst_a_rd1", a.ReadData1, 32'h0);
    chk("rst_a_rd2", a.ReadData2, 32'h0);
    chk("rst_a_busy", 32'(a.Busy), 32'h0);
    chk("rst_a_err", 32'(a.WriteErr), 32'h0);
    chk("rst_b_rd1", b.ReadData1, 32'h0);
    chk("rst_b_busy", 32'(b.Busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wr(5'd2, 32'd42);
    wr(5'd3, 32'd15);
    rr1 = 5'd2;
    rr2 = 5'd3;
    #1;
    chk("dual_a_rd1", a.ReadData1, 32'd42);
    chk("dual_a_rd2", a.ReadData2, 32'd15);
    chk("dual_b_rd1", b.ReadData1, 32'd42);
    wr(5'd2, 32'd15);
    rr2 = 5'd2;
    #1;
    chk("same_a_rd1", a.ReadData1, 32'd15);
    chk("same_a_rd2", a.ReadData2, 32'd15);
    wr(5'd0, 32'hFFFF_FFFF);
    rr1 = 5'd0;
    #1;
    chk("zero_a_rd1", a.ReadData1, 32'h0);
    chk("zero_a_err", 32'(a.WriteErr), 32'h0);
    chk("zero_b_rd1", b.ReadData1, 32'hFFFF_FFFF);
    @(negedge clk);
    rr1 = 5'd7;
    we = 1'b1;
    wa = 5'd7;
    wd = 32'hA5;
    #1;
    chk("byp_b_pre", b.ReadData1, 32'hA5);
    chk("nobyp_a_pre", a.ReadData1, 32'h0);
    @(negedge clk);
    we = 1'b0;
    #1;
    chk("nobyp_a_post", a.ReadData1, 32'hA5);
    chk("byp_b_post", b.ReadData1, 32'hA5);
    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i));
    rr1 = 5'd5;
    rr2 = 5'd20;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    for (int c = 0; c < 100 && (a.Busy || b.Busy); c++) begin
      if (c == 10) begin
        chk("clr10_a_r5", a.ReadData1, 32'h0);
        chk("clr10_a_r20", a.ReadData2, 32'd20);
        chk("clr10_b_r5", b.ReadData1, 32'h0);
        chk("clr10_b_r20", b.ReadData2, 32'd20);
      end
      if (c == 12) begin
        we = 1'b1;
        wa = 5'd30;
        wd = 32'h55;
      end
      if (c == 13) begin
        we = 1'b0;
        rr2 = 5'd30;
        #1;
        chk("werr_a_hi", 32'(a.WriteErr), 32'h1);
        chk("werr_b_hi", 32'(b.WriteErr), 32'h1);
      end
      if (c == 14) begin
        chk("werr_a_lo", 32'(a.WriteErr), 32'h0);
        chk("werr_b_lo", 32'(b.WriteErr), 32'h0);
        chk("drop_a_r30", a.ReadData2, 32'd30);
      end
      na += int'(a.Busy);
      nb += int'(b.Busy);
      @(negedge clk);
    end
    chk("busy_cycles_a", 32'(na), 32'd31);
    chk("busy_cycles_b", 32'(nb), 32'd32);
    chk("busy_end_a", 32'(a.Busy), 32'h0);
    for (int i = 0; i < 32; i++) begin
      rr1 = 5'(i);
      #1;
      chk($sformatf("clr_a_r%0d", i), a.ReadData1, 32'h0);
      chk($sformatf("clr_b_r%0d", i), b.ReadData1, 32'h0);
    end
    wr(5'd4, 32'd9);
    rr1 = 5'd4;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    chk("midclr_a_busy", 32'(a.Busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_a_busy", 32'(a.Busy), 32'h0);
    chk("abort_b_busy", 32'(b.Busy), 32'h0);
    chk("abort_b_r4", b.ReadData1, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_a_busy", 32'(a.Busy), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
